// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared FSM states, default sizes and address check for mem_responder
package mem_resp_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam int DEF_DEPTH_WORDS = 256;
  localparam int DEF_WAIT_CYCLES = 2;
  function automatic logic addr_bad(input logic [31:0] a, input int depth);
    return a[1:0] != 2'b0 || {2'b0, a[31:2]} >= 32'(depth);
  endfunction
endpackage

// File: rtl/mem_resp_array.sv
// mem_resp_array: word storage with synchronous write and registered read, never reset
module mem_resp_array #(
  parameter int DEPTH_WORDS = 256,
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH_WORDS];
  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding word memory responder with programmable wait states
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  state_t state, state_n;
  logic [3:0] cnt;
  logic we_q, mem_we, w;
  logic [31:0] addr_q, wdata_q, a, d, rd;
  always_comb begin
    state_n = state;
    a = state == IDLE ? addr : addr_q;
    d = state == IDLE ? wdata : wdata_q;
    w = state == IDLE ? we : we_q;
    if (state == IDLE && req) state_n = WAIT_CYCLES > 0 ? WAIT : RESP;
    else if (state == WAIT && cnt == 4'd0) state_n = RESP;
    else if (state == RESP) state_n = IDLE;
    mem_we = state_n == RESP && w && !addr_bad(a, DEPTH_WORDS) && !reset;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= 4'd0;
    end else begin
      state <= state_n;
      if (state == IDLE && req) begin
        we_q <= we;
        addr_q <= addr;
        wdata_q <= wdata;
        cnt <= 4'(WAIT_CYCLES - 1);
      end else if (state == WAIT) cnt <= cnt - 4'd1;
    end
  end
  mem_resp_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clock(clock),
    .we(mem_we),
    .addr(a[AW+1:2]),
    .wdata(d),
    .rdata(rd)
  );
  always_comb begin
    busy = state != IDLE;
    ack = state == RESP;
    err = ack && addr_bad(addr_q, DEPTH_WORDS);
    rdata = ack && !we_q && !err ? rd : 32'd0;
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of two responders (2 and 0 wait states) against a cycle-level model
module tb_mem_responder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req[2], we[2], ack[2], err[2], busy[2];
  logic [31:0] addr[2], wdata[2], rdata[2];
  int checks = 0, errors = 0, cyc = 0;
  bit started = 0;
  bit pend[2], eerr[2], eknown[2];
  int ackc[2];
  logic lwe[2];
  logic [31:0] laddr[2], lwd[2], erd[2];
  logic [31:0] mdl_mem [int];
  always #5 clk = ~clk;
  mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut0 (
    .clock(clk), .reset(reset), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .rdata(rdata[0]), .ack(ack[0]), .err(err[0]), .busy(busy[0])
  );
  mem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) dut1 (
    .clock(clk), .reset(reset), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .rdata(rdata[1]), .ack(ack[1]), .err(err[1]), .busy(busy[1])
  );
  function automatic int wc(input int d);
    return d == 0 ? 2 : 0;
  endfunction
  function automatic int dep(input int d);
    return d == 0 ? 256 : 16;
  endfunction
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) pend[d] = 0;
      else if (pend[d] && cyc == ackc[d]) pend[d] = 0;
      else if (!pend[d] && req[d]) begin
        pend[d] = 1;
        ackc[d] = cyc + wc(d) + 1;
        lwe[d] = we[d];
        laddr[d] = addr[d];
        lwd[d] = wdata[d];
      end
    end
    if (reset) started = 1;
    cyc = cyc + 1;
    for (int d = 0; d < 2; d++) begin
      if (pend[d] && cyc == ackc[d] && !reset) begin
        int key;
        key = d * 65536 + int'(laddr[d][31:2] % 65536);
        eknown[d] = 1;
        erd[d] = 32'd0;
        eerr[d] = laddr[d][1:0] != 2'b0 || laddr[d][31:2] >= 30'(dep(d));
        if (!eerr[d] && lwe[d]) mdl_mem[key] = lwd[d];
        else if (!eerr[d]) begin
          if (mdl_mem.exists(key)) erd[d] = mdl_mem[key];
          else eknown[d] = 0;
        end
      end
    end
    #1;
    if (started) begin
      for (int d = 0; d < 2; d++) begin
        logic eack;
        eack = pend[d] && cyc == ackc[d];
        checks++;
        if (ack[d] !== eack || busy[d] !== pend[d] || err[d] !== (eack && eerr[d]) ||
            ((!eack || eknown[d]) && rdata[d] !== (eack ? erd[d] : 32'd0))) begin
          errors++;
          $display("FAIL cycle_model dut%0d cyc %0d: ack=%b busy=%b err=%b rdata=%h required ack=%b busy=%b err=%b rdata=%h",
                   d, cyc, ack[d], busy[d], err[d], rdata[d], eack, pend[d], eack && eerr[d], eack ? erd[d] : 32'd0);
        end
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask
  task automatic txn(input string nm, input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                     input logic e_err, input logic [31:0] e_rd, input int e_lat);
    int t0;
    bit got;
    got = 0;
    @(negedge clk);
    req[d] = 1;
    we[d] = w;
    addr[d] = a;
    wdata[d] = wd;
    t0 = cyc;
    for (int i = 0; i < 30 && !got; i++) begin
      @(posedge clk);
      #1;
      got = ack[d] === 1'b1;
    end
    chk({nm, "_ack"}, 32'(got), 32'd1);
    if (got) begin
      chk({nm, "_lat"}, cyc - t0, e_lat);
      chk({nm, "_err"}, 32'(err[d]), 32'(e_err));
      chk({nm, "_rdata"}, rdata[d], e_rd);
    end
    @(negedge clk);
    req[d] = 0;
  endtask
  initial begin
    int t0, acks;
    int t[3];
    logic [31:0] v[3];
    bit got;
    for (int d = 0; d < 2; d++) begin
      req[d] = 0; we[d] = 0; addr[d] = 0; wdata[d] = 0;
    end
    repeat (2) @(negedge clk);
    reset = 0;
    chk("rst_busy", 32'(busy[0]), 0);
    chk("rst_ack", 32'(ack[0]), 0);
    chk("rst_err", 32'(err[0]), 0);
    chk("rst_rdata", rdata[0], 0);
    txn("st10", 0, 1, 32'h10, 32'hDEADBEEF, 0, 0, 3);
    txn("ld10", 0, 0, 32'h10, 0, 0, 32'hDEADBEEF, 3);
    txn("st20", 0, 1, 32'h20, 32'h11111111, 0, 0, 3);
    txn("ld13_mis", 0, 0, 32'h13, 0, 1, 0, 3);
    txn("st22_mis", 0, 1, 32'h22, 32'h12345678, 1, 0, 3);
    txn("ld20_keep", 0, 0, 32'h20, 0, 0, 32'h11111111, 3);
    txn("st0", 0, 1, 32'h0, 32'hA5A5A5A5, 0, 0, 3);
    txn("st400_oor", 0, 1, 32'h400, 32'h55555555, 1, 0, 3);
    txn("st3fc_last", 0, 1, 32'h3FC, 32'h0000_03FC, 0, 0, 3);
    txn("ld0_keep", 0, 0, 32'h0, 0, 0, 32'hA5A5A5A5, 3);
    @(negedge clk);
    req[0] = 1; we[0] = 0; addr[0] = 32'h10; t0 = cyc;
    for (int k = 0; k < 3; k++) begin
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(posedge clk);
        #1;
        got = ack[0] === 1'b1;
      end
      chk("b2b_ack", 32'(got), 1);
      t[k] = cyc;
      v[k] = rdata[0];
      @(negedge clk);
      if (k == 0) addr[0] = 32'h20;
      else if (k == 1) addr[0] = 32'h0;
      else req[0] = 0;
    end
    chk("b2b_lat0", t[0] - t0, 3);
    chk("b2b_gap1", t[1] - t[0], 4);
    chk("b2b_gap2", t[2] - t[1], 4);
    chk("b2b_v0", v[0], 32'hDEADBEEF);
    chk("b2b_v1", v[1], 32'h11111111);
    chk("b2b_v2", v[2], 32'hA5A5A5A5);
    txn("st8_pre", 0, 1, 32'h8, 32'h12121212, 0, 0, 3);
    acks = 0;
    @(negedge clk);
    req[0] = 1; we[0] = 1; addr[0] = 32'h8; wdata[0] = 32'hCAFEF00D;
    @(posedge clk); #1; acks += int'(ack[0]);
    @(posedge clk); #1; acks += int'(ack[0]);
    @(negedge clk);
    reset = 1; req[0] = 0;
    @(posedge clk); #1; acks += int'(ack[0]);
    chk("rstmid_busy", 32'(busy[0]), 0);
    @(negedge clk);
    reset = 0;
    repeat (4) begin
      @(posedge clk); #1; acks += int'(ack[0]);
    end
    chk("rstmid_noack", acks, 0);
    txn("ld8_pre", 0, 0, 32'h8, 0, 0, 32'h12121212, 3);
    txn("ld10_after_rst", 0, 0, 32'h10, 0, 0, 32'hDEADBEEF, 3);
    txn("w0_st3c", 1, 1, 32'h3C, 32'h00000077, 0, 0, 1);
    txn("w0_ld3c", 1, 0, 32'h3C, 0, 0, 32'h00000077, 1);
    txn("w0_st40_oor", 1, 1, 32'h40, 32'h99, 1, 0, 1);
    txn("w0_ld2_mis", 1, 0, 32'h2, 0, 1, 0, 1);
    txn("w0_st4", 1, 1, 32'h4, 32'hFEEDFACE, 0, 0, 1);
    txn("w0_ld4", 1, 0, 32'h4, 0, 0, 32'hFEEDFACE, 1);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit storage words.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, meaning the number of wait states inserted before each response (legal range 0..15).
REQ-003 Port clock  input  1  the single clock; all state updates occur on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port req  input  1  initiator request strobe, held high until ack.
REQ-006 Port we  input  1  1 = store word, 0 = load word; sampled with req.
REQ-007 Port addr  input  32  byte address; sampled with req.
REQ-008 Port wdata  input  32  store data; sampled with req.
REQ-009 Port rdata  output  32  load data; valid only while ack=1.
REQ-010 Port ack  output  1  one-cycle response strobe.
REQ-011 Port err  output  1  response error flag; valid only while ack=1.
REQ-012 Port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-014 In IDLE with req=1 at a rising edge: latch we/addr/wdata; go to WAIT if WAIT_CYCLES>0 (counter loaded with WAIT_CYCLES-1), else go to RESP.
REQ-015 In IDLE with req=0: stay in IDLE; no storage access.
REQ-016 In WAIT: counter decrements each edge; at counter=0 go to RESP.
REQ-017 In RESP: ack=1 for exactly one cycle, then unconditionally return to IDLE.
REQ-018 Latency: req sampled in cycle N -> ack high in cycle N+WAIT_CYCLES+1 (WAIT_CYCLES=2 -> cycle N+3; WAIT_CYCLES=0 -> cycle N+1).
REQ-019 Only one outstanding request; req, we, addr, wdata are ignored outside IDLE.
REQ-020 req still high in the cycle after ack (back in IDLE) SHALL be accepted as a new request.
REQ-021 Error condition: latched addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS -> err=1 with ack, rdata=0, no write.
REQ-022 Valid store: the word at index addr[31:2] is written with wdata on the edge entering RESP; rdata=0 during that ack.
REQ-023 Valid load: rdata = stored word at index addr[31:2] during the ack cycle, reflecting all previously acknowledged stores.
REQ-024 Storage contents are not initialised; a load of a never-written word returns an unspecified value, with err=0.
REQ-025 Outside RESP: ack=0, err=0, rdata=0.

Reset
REQ-026 Reset=1 at a rising edge SHALL force IDLE, counter=0, ack=0, err=0, rdata=0, busy=0 in the following cycle.
REQ-027 Reset during WAIT or on the edge entering RESP SHALL abort the request: no write committed, no ack issued.
REQ-028 Reset SHALL NOT clear the storage array.
REQ-029 Reset takes priority over req at the same edge; that request is discarded.

Structure
REQ-030 Package mem_resp_pkg SHALL hold the state enum (IDLE, WAIT, RESP) and the default DEPTH_WORDS/WAIT_CYCLES constants.
REQ-031 Storage SHALL be a sub-module mem_resp_array: DEPTH_WORDS x 32, synchronous write, registered read, no reset.
REQ-032 The FSM, wait counter, request latches, and error check SHALL reside in mem_responder.

Verification
REQ-033 Store/load, WAIT_CYCLES=2: store 0xDEADBEEF to 0x10 in cycle 0 -> ack in cycle 3, err=0; load 0x10 -> ack 3 cycles after req, rdata=0xDEADBEEF.
REQ-034 Misaligned: load 0x13 -> ack, err=1, rdata=0; store 0x22 with 0x12345678 -> err=1; a later load of 0x20 returns its prior value.
REQ-035 Out of range, DEPTH_WORDS=256: store to 0x400 -> err=1; word 0 is unchanged.
REQ-036 Back-to-back: req held high over 3 loads -> 3 acks spaced 4 cycles apart (WAIT_CYCLES=2); busy low only in the accept cycles.
REQ-037 Reset mid-operation: store 0xCAFEF00D to 0x8, reset in cycle 2 -> no ack; a load of 0x8 returns the pre-store value.
REQ-038 WAIT_CYCLES=0: req in cycle N -> ack in cycle N+1; WAIT is never entered.
